// File: rtl/scalu_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : scalu_rs_if
// Description : Bundle of the dispatch, issue, writeback-snoop and flush
//               signals around the scalar-ALU reservation station.
//               master = upstream/downstream environment side,
//               slave  = reservation station side.
// Ports       : dispatch_* (dispatch request and operands), exers_* (issue
//               to ALU and full indication), scalu_stall, wb_* (writeback
//               broadcast), rob_flush.
// Revision    : 1.0 - initial release
// ============================================================================
interface scalu_rs_if #(
  parameter int TAGW = 7
);
  logic            dispatch_valid;
  logic [4:0]      dispatch_op;
  logic [TAGW-1:0] dispatch_robid;
  logic [5:0]      dispatch_rd;
  logic            dispatch_op1_ready;
  logic [31:0]     dispatch_op1;
  logic            dispatch_op2_ready;
  logic [31:0]     dispatch_op2;
  logic            exers_stall;
  logic            exers_scalu_issue;
  logic [4:0]      exers_scalu_op;
  logic [TAGW-1:0] exers_robid;
  logic [5:0]      exers_rd;
  logic [31:0]     exers_op1;
  logic [31:0]     exers_op2;
  logic            scalu_stall;
  logic            wb_valid;
  logic [TAGW-1:0] wb_robid;
  logic [31:0]     wb_result;
  logic            rob_flush;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
           dispatch_op1_ready, dispatch_op1, dispatch_op2_ready, dispatch_op2,
           scalu_stall, wb_valid, wb_robid, wb_result, rob_flush,
    input  exers_stall, exers_scalu_issue, exers_scalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
           dispatch_op1_ready, dispatch_op1, dispatch_op2_ready, dispatch_op2,
           scalu_stall, wb_valid, wb_robid, wb_result, rob_flush,
    output exers_stall, exers_scalu_issue, exers_scalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );
endinterface
`default_nettype wire

// File: rtl/scalu_rs.sv
`default_nettype none
// ============================================================================
// Module      : scalu_rs
// Description : Reservation station feeding the single-cycle scalar ALU.
//               Holds dispatched micro-ops until both operands are present
//               (captured at dispatch or snooped from the writeback bus) and
//               issues the oldest ready entry whenever the ALU accepts.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               bus        - scalu_rs_if slave modport (dispatch, issue,
//                            writeback snoop, ALU stall, ROB flush)
// Revision    : 1.0 - initial release
// ============================================================================
module scalu_rs #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 7
) (
  input  wire logic   clk,
  input  wire logic   rst,
  scalu_rs_if.slave   bus
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] C_FULL = CNTW'(DEPTH);

  // Per-entry state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy2_q;
  logic [4:0]       op_q    [DEPTH];
  logic [TAGW-1:0]  robid_q [DEPTH];
  logic [5:0]       rd_q    [DEPTH];
  logic [31:0]      val1_q  [DEPTH];
  logic [31:0]      val2_q  [DEPTH];
  // age_q[i][j] = 1 means entry i was allocated before entry j
  logic [DEPTH-1:0] age_q   [DEPTH];
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_sel;
  logic             w_stall;
  logic             w_issue;
  logic             w_disp;
  logic [IDXW-1:0]  w_alloc;
  logic             w_byp1, w_byp2;
  logic             w_flush;

  assign w_flush = rst | bus.rob_flush;

  // Full indication comes from registered occupancy only, so a slot freed
  // by this cycle's issue is not offered to this cycle's dispatch.
  assign w_stall = (cnt_q == C_FULL);
  assign w_ready = valid_q & rdy1_q & rdy2_q;
  assign w_issue = (|w_ready) & ~bus.scalu_stall & ~bus.rob_flush;
  assign w_disp  = bus.dispatch_valid & ~w_stall & ~bus.rob_flush;

  // Oldest-ready select: an entry wins when it is older than every other
  // ready entry. Allocation order is total, so at most one bit is set.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    logic w_oldest;
    always_comb begin
      w_oldest = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != gi) && w_ready[j] && !age_q[gi][j]) begin
          w_oldest = 1'b0;
        end
      end
    end
    assign w_sel[gi] = w_ready[gi] & w_oldest;
  end

  // Lowest-index free slot
  always_comb begin
    w_alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        w_alloc = IDXW'(i);
      end
    end
  end

  // Same-cycle writeback of a not-yet-ready dispatching operand
  assign w_byp1 = ~bus.dispatch_op1_ready & bus.wb_valid &
                  (bus.dispatch_op1[TAGW-1:0] == bus.wb_robid);
  assign w_byp2 = ~bus.dispatch_op2_ready & bus.wb_valid &
                  (bus.dispatch_op2[TAGW-1:0] == bus.wb_robid);

  // Issue data mux (one-hot AND-OR)
  always_comb begin
    bus.exers_scalu_op = '0;
    bus.exers_robid    = '0;
    bus.exers_rd       = '0;
    bus.exers_op1      = '0;
    bus.exers_op2      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        bus.exers_scalu_op = bus.exers_scalu_op | op_q[i];
        bus.exers_robid    = bus.exers_robid    | robid_q[i];
        bus.exers_rd       = bus.exers_rd       | rd_q[i];
        bus.exers_op1      = bus.exers_op1      | val1_q[i];
        bus.exers_op2      = bus.exers_op2      | val2_q[i];
      end
    end
  end

  assign bus.exers_scalu_issue = w_issue;
  assign bus.exers_stall       = w_stall;

  always_comb begin
    valid_d = valid_q;
    if (w_issue) begin
      valid_d = valid_d & ~w_sel;
    end
    if (w_disp) begin
      valid_d[w_alloc] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_disp && !w_issue) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (!w_disp && w_issue) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;

      // Writeback snoop on resident entries; both operands may wake at once
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wb_valid && valid_q[i] && !rdy1_q[i] &&
            (val1_q[i][TAGW-1:0] == bus.wb_robid)) begin
          rdy1_q[i] <= 1'b1;
          val1_q[i] <= bus.wb_result;
        end
        if (bus.wb_valid && valid_q[i] && !rdy2_q[i] &&
            (val2_q[i][TAGW-1:0] == bus.wb_robid)) begin
          rdy2_q[i] <= 1'b1;
          val2_q[i] <= bus.wb_result;
        end
      end

      // The allocated slot is free, so the snoop above never touched it.
      if (w_disp) begin
        op_q[w_alloc]    <= bus.dispatch_op;
        robid_q[w_alloc] <= bus.dispatch_robid;
        rd_q[w_alloc]    <= bus.dispatch_rd;
        rdy1_q[w_alloc]  <= bus.dispatch_op1_ready | w_byp1;
        val1_q[w_alloc]  <= w_byp1 ? bus.wb_result : bus.dispatch_op1;
        rdy2_q[w_alloc]  <= bus.dispatch_op2_ready | w_byp2;
        val2_q[w_alloc]  <= w_byp2 ? bus.wb_result : bus.dispatch_op2;
        // New entry is younger than every currently resident entry; the
        // full row and column are rewritten so stale bits never survive.
        for (int j = 0; j < DEPTH; j++) begin
          age_q[w_alloc][j] <= 1'b0;
          age_q[j][w_alloc] <= valid_q[j];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scalu_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalu_rs
// Description : Directed self-checking bench for scalu_rs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalu_rs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  scalu_rs_if #(.TAGW(7)) bus ();

  scalu_rs #(.DEPTH(8), .TAGW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [6:0] robid,
                           input logic [31:0] op1, input logic [31:0] op2);
    chk({tag, ".issue"}, 32'(bus.exers_scalu_issue), 32'd1);
    chk({tag, ".robid"}, 32'(bus.exers_robid), 32'(robid));
    chk({tag, ".op1"}, bus.exers_op1, op1);
    chk({tag, ".op2"}, bus.exers_op2, op2);
  endtask

  task automatic idle();
    bus.dispatch_valid     = 1'b0;
    bus.dispatch_op        = '0;
    bus.dispatch_robid     = '0;
    bus.dispatch_rd        = '0;
    bus.dispatch_op1_ready = 1'b0;
    bus.dispatch_op1       = '0;
    bus.dispatch_op2_ready = 1'b0;
    bus.dispatch_op2       = '0;
    bus.wb_valid           = 1'b0;
    bus.wb_robid           = '0;
    bus.wb_result          = '0;
    bus.rob_flush          = 1'b0;
  endtask

  task automatic disp(input logic [6:0] robid, input logic [4:0] op,
                      input logic r1, input logic [31:0] v1,
                      input logic r2, input logic [31:0] v2);
    bus.dispatch_valid     = 1'b1;
    bus.dispatch_op        = op;
    bus.dispatch_robid     = robid;
    bus.dispatch_rd        = robid[5:0];
    bus.dispatch_op1_ready = r1;
    bus.dispatch_op1       = v1;
    bus.dispatch_op2_ready = r2;
    bus.dispatch_op2       = v2;
  endtask

  task automatic wb(input logic [6:0] tag, input logic [31:0] res);
    bus.wb_valid  = 1'b1;
    bus.wb_robid  = tag;
    bus.wb_result = res;
  endtask

  initial begin
    idle();
    bus.scalu_stall = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset.stall", 32'(bus.exers_stall), 32'd0);
    chk("reset.issue", 32'(bus.exers_scalu_issue), 32'd0);

    // Both operands ready: issues one cycle after dispatch
    disp(7'd3, 5'd1, 1'b1, 32'd5, 1'b1, 32'd7);
    #1;
    chk("add.pre_issue", 32'(bus.exers_scalu_issue), 32'd0);
    tick();
    idle();
    #1;
    chk_issue("add", 7'd3, 32'd5, 32'd7);
    chk("add.op", 32'(bus.exers_scalu_op), 32'd1);
    chk("add.rd", 32'(bus.exers_rd), 32'd3);
    tick();
    chk("add.freed", 32'(bus.exers_scalu_issue), 32'd0);

    // Wakeup from a later broadcast
    disp(7'd4, 5'd2, 1'b0, 32'd9, 1'b1, 32'd2);
    tick();
    idle();
    #1;
    chk("wake.wait1", 32'(bus.exers_scalu_issue), 32'd0);
    tick();
    chk("wake.wait2", 32'(bus.exers_scalu_issue), 32'd0);
    wb(7'd9, 32'h1234);
    #1;
    chk("wake.bcast_cycle", 32'(bus.exers_scalu_issue), 32'd0);
    tick();
    idle();
    #1;
    chk_issue("wake", 7'd4, 32'h1234, 32'd2);
    tick();
    chk("wake.freed", 32'(bus.exers_scalu_issue), 32'd0);

    // Fill all 8, ninth ignored, mass wakeup drains in dispatch order
    for (int k = 0; k < 8; k++) begin
      disp(7'(20 + k), 5'd3, 1'b1, 32'(k), 1'b0, 32'd50);
      #1;
      chk("fill.stall", 32'(bus.exers_stall), 32'd0);
      tick();
      chk("fill.issue", 32'(bus.exers_scalu_issue), 32'd0);
    end
    disp(7'd28, 5'd3, 1'b1, 32'd99, 1'b1, 32'd99);
    #1;
    chk("full.stall", 32'(bus.exers_stall), 32'd1);
    tick();
    idle();
    #1;
    chk("full.ninth_ignored", 32'(bus.exers_scalu_issue), 32'd0);
    wb(7'd50, 32'hAAAA);
    tick();
    idle();
    #1;
    chk_issue("drain0", 7'd20, 32'd0, 32'hAAAA);
    chk("drain0.stall", 32'(bus.exers_stall), 32'd1);
    tick();
    chk("drain1.stall", 32'(bus.exers_stall), 32'd0);
    for (int k = 1; k < 8; k++) begin
      chk_issue("drain", 7'(20 + k), 32'(k), 32'hAAAA);
      tick();
    end
    chk("drain.empty", 32'(bus.exers_scalu_issue), 32'd0);

    // ALU stall held for three cycles with two ready entries
    bus.scalu_stall = 1'b1;
    disp(7'd30, 5'd4, 1'b1, 32'd300, 1'b1, 32'd301);
    tick();
    disp(7'd31, 5'd4, 1'b1, 32'd310, 1'b1, 32'd311);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("stall.hold", 32'(bus.exers_scalu_issue), 32'd0);
      tick();
    end
    bus.scalu_stall = 1'b0;
    #1;
    chk_issue("stall.first", 7'd30, 32'd300, 32'd301);
    tick();
    chk_issue("stall.second", 7'd31, 32'd310, 32'd311);
    tick();
    chk("stall.empty", 32'(bus.exers_scalu_issue), 32'd0);

    // Dispatch-time bypass from a same-cycle broadcast
    disp(7'd40, 5'd5, 1'b0, 32'd12, 1'b1, 32'd3);
    wb(7'd12, 32'hFF);
    tick();
    idle();
    #1;
    chk_issue("bypass", 7'd40, 32'hFF, 32'd3);
    tick();

    // Age order independent of slot index: younger entry sits in slot 0
    disp(7'd50, 5'd6, 1'b1, 32'd1, 1'b1, 32'd2);
    tick();
    chk_issue("age.x", 7'd50, 32'd1, 32'd2);
    disp(7'd51, 5'd6, 1'b0, 32'd61, 1'b1, 32'd8);
    tick();
    disp(7'd52, 5'd6, 1'b1, 32'd9, 1'b0, 32'd61);
    #1;
    chk("age.wait", 32'(bus.exers_scalu_issue), 32'd0);
    tick();
    idle();
    wb(7'd61, 32'h77);
    tick();
    idle();
    #1;
    chk_issue("age.older", 7'd51, 32'h77, 32'd8);
    tick();
    chk_issue("age.younger", 7'd52, 32'd9, 32'h77);
    tick();
    chk("age.empty", 32'(bus.exers_scalu_issue), 32'd0);

    // Flush with five resident entries and a concurrent dispatch
    bus.scalu_stall = 1'b1;
    disp(7'd80, 5'd7, 1'b1, 32'd80, 1'b1, 32'd80);
    tick();
    disp(7'd81, 5'd7, 1'b1, 32'd81, 1'b1, 32'd81);
    tick();
    for (int k = 0; k < 3; k++) begin
      disp(7'(82 + k), 5'd7, 1'b0, 32'd70, 1'b1, 32'd0);
      tick();
    end
    idle();
    bus.scalu_stall = 1'b0;
    bus.rob_flush   = 1'b1;
    disp(7'd85, 5'd7, 1'b1, 32'd85, 1'b1, 32'd85);
    #1;
    chk("flush.issue", 32'(bus.exers_scalu_issue), 32'd0);
    tick();
    idle();
    #1;
    chk("flush.after_issue", 32'(bus.exers_scalu_issue), 32'd0);
    chk("flush.after_stall", 32'(bus.exers_stall), 32'd0);
    wb(7'd70, 32'h5555);
    tick();
    idle();
    #1;
    chk("flush.no_wake", 32'(bus.exers_scalu_issue), 32'd0);
    tick();
    chk("flush.no_wake2", 32'(bus.exers_scalu_issue), 32'd0);
    // Occupancy must restart from zero: four more dispatches must not fill
    for (int k = 0; k < 4; k++) begin
      disp(7'(90 + k), 5'd8, 1'b0, 32'd100, 1'b0, 32'd100);
      tick();
      idle();
      #1;
      chk("flush.refill_stall", 32'(bus.exers_stall), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scalu_rs.md
Name: scalu_rs

Overview:
- Reservation station directly upstream of the single-cycle scalar ALU.
- Buffers dispatched ALU micro-ops until both source operands are available, captured either at dispatch or by snooping the writeback broadcast.
- Issues the oldest ready entry to the ALU each cycle the ALU is not stalled.
- Clears all entries on reset or ROB flush.

Parameters:
- DEPTH, 8, number of station entries (power of two, 2..16).
- TAGW, 7, producer tag width; equals the ROB id width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- dispatch_valid  input  1  dispatch request this cycle
- dispatch_op  input  5  ALU opcode
- dispatch_robid  input  7  ROB id of the instruction
- dispatch_rd  input  6  destination physical register
- dispatch_op1_ready  input  1  op1 holds a value (1) or a tag (0)
- dispatch_op1  input  32  op1 value, or producer tag in bits [TAGW-1:0]
- dispatch_op2_ready  input  1  as op1_ready, for op2
- dispatch_op2  input  32  as op1, for op2
- exers_stall  output  1  station full; dispatch is not accepted
- exers_scalu_issue  output  1  issue valid to the ALU
- exers_scalu_op  output  5  issued opcode
- exers_robid  output  7  issued ROB id
- exers_rd  output  6  issued destination
- exers_op1  output  32  issued op1 value
- exers_op2  output  32  issued op2 value
- scalu_stall  input  1  ALU cannot accept an issue this cycle
- wb_valid  input  1  writeback broadcast valid
- wb_robid  input  7  tag of the broadcast result
- wb_result  input  32  broadcast result value
- rob_flush  input  1  squash all entries

Behaviour:
- Per-entry state: valid, op, robid, rd, rdy1, val1, rdy2, val2. An age matrix records allocation order.
- Reset and flush, on the clock edge with rst or rob_flush high:
  - all valid bits clear and the age matrix clears;
  - any dispatch or issue in that cycle is discarded.
- Outputs after reset or flush:
  - exers_stall = 0 and exers_scalu_issue = 0;
  - data outputs are don't-care while issue = 0.
- Full/stall:
  - exers_stall = 1 exactly when all DEPTH entries are valid.
  - It is registered state, not combinational on this cycle's issue.
  - A dispatch_valid while exers_stall = 1 is ignored; the upstream holds and retries.
- Dispatch, when dispatch_valid and not exers_stall:
  - writes the lowest-index free entry at the clock edge;
  - marks that entry youngest.
- Dispatch bypass: if a dispatching operand is not ready and its tag equals wb_robid while wb_valid:
  - the entry is written with rdy = 1 and val = wb_result.
- Wakeup: each cycle wb_valid is high, every valid entry operand with rdy = 0 and tag == wb_robid sets rdy = 1 and val = wb_result at the edge.
  - Both operands of one entry may wake from the same broadcast.
- Ready rule: an entry is ready when valid & rdy1 & rdy2.
  - Ready is evaluated on registered state only, so a woken or newly dispatched entry can issue no earlier than the following cycle.
- Select and issue:
  - exers_scalu_issue = any entry ready & ~scalu_stall & ~rob_flush, combinational.
  - Data outputs carry the oldest ready entry per the age matrix.
  - When issue is 1, that entry's valid clears at the edge.
- Stall behaviour: while scalu_stall is 1, no entry is freed and the selection is re-evaluated the next cycle.
- Simultaneous events:
  - Issue and dispatch in the same cycle are both performed.
  - The freed slot is not reusable until the next cycle, because stall is computed from registered occupancy.
- Occupancy counter: 0..DEPTH; +1 on dispatch, -1 on issue, unchanged when both occur.
- Latency: minimum dispatch-to-issue is 1 cycle, for an entry dispatched with both operands ready.

Test Plan:
- Reset, then dispatch op=ADD robid=3 with op1=5 and op2=7, both ready. Required: issue=1 with robid=3, op1=5, op2=7 the next cycle, and the entry is freed.
- Dispatch robid=4 with op1 a tag of 9 (not ready). Two cycles later drive wb_valid, wb_robid=9, wb_result=0x1234. Required: issue with op1=0x1234 in the cycle after the broadcast, not before.
- Dispatch 8 entries with their op2 not ready. Required: exers_stall=1 after the eighth, and a ninth dispatch is ignored. Then wake all 8 with one broadcast; required: issues occur in dispatch order, and exers_stall drops the cycle after the first issue.
- Hold scalu_stall=1 for 3 cycles with 2 ready entries. Required: issue=0 throughout the stall; then the oldest entry issues first and the next entry issues in the following cycle.
- Dispatch with tag 12 while wb_valid, wb_robid=12, wb_result=0xFF in the same cycle. Required: the entry issues the next cycle with op=0xFF.
- Fill 5 entries and assert rob_flush together with a dispatch. Required: issue=0 that cycle, no entries remain afterwards, and a later broadcast causes no issue.
